// File: rtl/exhaustive_vector_sequencer_pkg.sv
// exhaustive_vector_sequencer_pkg: state encoding and settle-counter sizing
// shared by the exhaustive vector sequencer and its helpers.
package exhaustive_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int cnt_width(input int hold);
        return $clog2(hold) + 1;
    endfunction

endpackage

// File: rtl/exhaustive_vector_sequencer_vec_gray_encode.sv
// vec_gray_encode: combinational binary-to-Gray converter of width W.
module vec_gray_encode #(
    parameter int W = 3
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// exhaustive_vector_sequencer: walks all 2^IN_W input vectors, holds each for
// HOLD_CYCLES, compares DUT against reference once per vector and logs errors.
module exhaustive_vector_sequencer
    import exhaustive_vector_sequencer_pkg::*;
#(
    parameter int IN_W        = 3,
    parameter int OUT_W       = 2,
    parameter int HOLD_CYCLES = 1,
    parameter int GRAY        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] exp_out,
    output logic [IN_W-1:0]  vec_out,
    output logic             busy,
    output logic             sample_strobe,
    output logic             done,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [IN_W-1:0]  IDX_ONE  = 1;
    localparam logic [IN_W:0]    ERR_ONE  = 1;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W:0]    err_q, err_d;
    logic [IN_W-1:0]  fev_q, fev_d;
    logic             fevv_q, fevv_d;
    logic [IN_W-1:0]  idx_inc, idx_gray, vec_nxt;

    assign idx_inc = idx_q + IDX_ONE;
    assign vec_nxt = (GRAY != 0) ? idx_gray : idx_inc;

    vec_gray_encode #(.W(IN_W)) u_gray (
        .bin_i  (idx_inc),
        .gray_o (idx_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = '0;
                    vec_d   = '0;
                    cnt_d   = CNT_LOAD;
                    err_d   = '0;
                    fev_d   = '0;
                    fevv_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    vec_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    vec_d   = '0;
                end else begin
                    if (dut_out != exp_out) begin
                        err_d = err_q + ERR_ONE;
                        // only the first mismatch of a run is captured
                        fev_d  = fevv_q ? fev_q : vec_q;
                        fevv_d = 1'b1;
                    end
                    if (&idx_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                        idx_d   = idx_inc;
                        vec_d   = vec_nxt;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
        endcase
    end

    assign vec_out         = vec_q;
    assign busy            = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign sample_strobe   = (state_q == ST_SAMPLE);
    assign done            = (state_q == ST_DONE);
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevv_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// tb_exhaustive_vector_sequencer: drives a binary/hold-1 and a Gray/hold-2
// sequencer against a toy circuit whose reference is corrupted per vector.
module tb_exhaustive_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s [2];
    logic       abort_s [2];
    logic [7:0] mask_s  [2];
    logic [2:0] vec_o   [2];
    logic       busy_o  [2];
    logic       strb_o  [2];
    logic       done_o  [2];
    logic [3:0] err_o   [2];
    logic [2:0] fev_o   [2];
    logic       fevv_o  [2];
    logic [1:0] dut0, exp0, dut1, exp1;

    int n_cmp = 0;
    int n_bad = 0;
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    always #5 clk = ~clk;

    // toy circuit plus a reference that is wrong wherever the mask bit is set
    assign dut0 = vec_o[0][1:0] ^ {2{vec_o[0][2]}};
    assign exp0 = dut0 ^ {1'b0, mask_s[0][vec_o[0]]};
    assign dut1 = vec_o[1][1:0] ^ {2{vec_o[1][2]}};
    assign exp1 = dut1 ^ {1'b0, mask_s[1][vec_o[1]]};

    exhaustive_vector_sequencer #(.IN_W(3), .OUT_W(2), .HOLD_CYCLES(1), .GRAY(0)) u_bin (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .dut_out(dut0), .exp_out(exp0), .vec_out(vec_o[0]), .busy(busy_o[0]),
        .sample_strobe(strb_o[0]), .done(done_o[0]), .err_count(err_o[0]),
        .first_err_vec(fev_o[0]), .first_err_valid(fevv_o[0])
    );

    exhaustive_vector_sequencer #(.IN_W(3), .OUT_W(2), .HOLD_CYCLES(2), .GRAY(1)) u_gray (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .dut_out(dut1), .exp_out(exp1), .vec_out(vec_o[1]), .busy(busy_o[1]),
        .sample_strobe(strb_o[1]), .done(done_o[1]), .err_count(err_o[1]),
        .first_err_vec(fev_o[1]), .first_err_valid(fevv_o[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input int s, input string tag);
        check({tag, "_vec"},  int'(vec_o[s]),  0);
        check({tag, "_busy"}, int'(busy_o[s]), 0);
        check({tag, "_strb"}, int'(strb_o[s]), 0);
        check({tag, "_done"}, int'(done_o[s]), 0);
        check({tag, "_err"},  int'(err_o[s]),  0);
        check({tag, "_fev"},  int'(fev_o[s]),  0);
        check({tag, "_fevv"}, int'(fevv_o[s]), 0);
    endtask

    // one run; restart_v/abort_v/rst_v (-1 = unused) inject start, abort or rst mid-run
    task automatic run(input int s, input logic [7:0] m, input int restart_v,
                       input int abort_v, input int rst_v);
        int  h = s ? 2 : 1;
        int  c = 0;
        int  n = 0;
        int  v;
        int  errs = 0;
        int  first = 0;
        bit  have = 0;
        bit  restarted = 0;
        bit  ab = 0;
        bit  rs = 0;
        mask_s[s] = m;
        @(negedge clk);
        start_s[s] = 1'b1;
        @(posedge clk);
        #1;
        start_s[s] = 1'b0;
        check("start_busy", int'(busy_o[s]), 1);
        check("start_vec",  int'(vec_o[s]),  0);
        check("start_err",  int'(err_o[s]),  0);
        check("start_fevv", int'(fevv_o[s]), 0);
        check("start_done", int'(done_o[s]), 0);
        forever begin
            @(posedge clk);
            #1;
            c++;
            if (ab) begin
                abort_s[s] = 1'b0;
                check("abort_busy", int'(busy_o[s]), 0);
                check("abort_done", int'(done_o[s]), 0);
                check("abort_vec",  int'(vec_o[s]),  0);
                check("abort_err",  int'(err_o[s]),  errs);
                check("abort_fevv", int'(fevv_o[s]), int'(have));
                check("abort_fev",  int'(fev_o[s]),  first);
                return;
            end
            if (rs) begin
                rst = 1'b0;
                check_cleared(s, "midrst");
                return;
            end
            if (c > 100) begin
                check("timeout_done", int'(done_o[s]), 1);
                return;
            end
            if (strb_o[s]) begin
                v = s ? gray_tab[n] : n;
                check("strobe_vec",  int'(vec_o[s]), v);
                check("strobe_time", c, n * (h + 1) + h);
                if (v == rst_v) begin
                    rst = 1'b1;
                    rs = 1;
                end else if (m[v]) begin
                    errs++;
                    if (!have) first = v;
                    have = 1;
                end
                n++;
            end else if (done_o[s]) begin
                check("done_time", c, 8 * (h + 1));
                check("done_vec",  int'(vec_o[s]),  s ? gray_tab[7] : 7);
                check("done_err",  int'(err_o[s]),  errs);
                check("done_fevv", int'(fevv_o[s]), int'(have));
                check("done_fev",  int'(fev_o[s]),  first);
                return;
            end else begin
                check("run_busy", int'(busy_o[s]), 1);
                if (int'(vec_o[s]) == abort_v) begin
                    abort_s[s] = 1'b1;
                    ab = 1;
                end
            end
            start_s[s] = (int'(vec_o[s]) == restart_v) && !restarted && !strb_o[s];
            if (start_s[s]) restarted = 1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            mask_s[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_cleared(0, "reset0");
        check_cleared(1, "reset1");
        rst = 1'b0;
        run(0, 8'h00, -1, -1, -1);
        run(0, 8'h20, -1, -1, -1);
        run(0, 8'he0, -1, -1, -1);
        run(1, 8'h00, -1, -1, -1);
        run(1, 8'h30, -1, -1, -1);
        run(0, 8'h0a, 3, 4, -1);
        run(0, 8'h04 | 8'($urandom), -1, -1, 2);
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(1, 0)), 8'($urandom), -1, -1, -1);
        end
        run(1, 8'($urandom), -1, 5, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
